// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: turns a valid/ready command stream into pipelined AHB-Lite single transfers.
// Slot A drives the address phase, slot D the data phase; both advance together on HREADY.
module ahbl_cmd_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);
  logic        r_a_valid, r_a_err, r_d_valid, r_d_err, r_d_write;
  logic [1:0]  r_d_size, r_d_addr;
  logic [31:0] r_a_wdata;
  logic        w_illegal;
  logic [31:0] w_wdata, w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign cmd_ready = HREADY;
  assign busy      = r_a_valid | r_d_valid;
  assign w_illegal = (cmd_size > 3'd2) | (cmd_size == 3'd1 & cmd_addr[0]) |
                     (cmd_size == 3'd2 & |cmd_addr[1:0]);
  assign w_wdata   = cmd_size == 3'd0 ? {4{cmd_wdata[7:0]}} :
                     cmd_size == 3'd1 ? {2{cmd_wdata[15:0]}} : cmd_wdata;
  assign w_byte    = HRDATA[{r_d_addr, 3'b000} +: 8];
  assign w_half    = r_d_addr[1] ? HRDATA[31:16] : HRDATA[15:0];
  assign w_rdata   = (r_d_write | r_d_err) ? 32'd0 :
                     r_d_size == 2'd0 ? {24'd0, w_byte} :
                     r_d_size == 2'd1 ? {16'd0, w_half} : HRDATA;
  // The A slot's address/size/write live directly in the HADDR/HSIZE/HWRITE registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_a_valid <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_wdata <= '0;
      r_d_valid <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_write <= 1'b0;
      r_d_size  <= '0;
      r_d_addr  <= '0;
      HADDR     <= '0;
      HTRANS    <= 2'b00;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (HREADY) begin
      r_d_valid <= r_a_valid;
      r_d_err   <= r_a_err;
      r_d_write <= HWRITE;
      r_d_size  <= HSIZE[1:0];
      r_d_addr  <= HADDR[1:0];
      HWDATA    <= r_a_wdata;
      rsp_valid <= r_d_valid;
      if (r_d_valid) begin
        rsp_err   <= r_d_err;
        rsp_rdata <= w_rdata;
      end
      r_a_valid <= cmd_valid;
      HWRITE    <= cmd_valid & cmd_write;
      HTRANS    <= (cmd_valid & ~w_illegal) ? 2'b10 : 2'b00;
      if (cmd_valid) begin
        r_a_err   <= w_illegal;
        HADDR     <= cmd_addr;
        HSIZE     <= cmd_size;
        r_a_wdata <= w_wdata;
      end
    end else begin
      rsp_valid <= 1'b0;
    end
  end
endmodule
